debug_trace_streamer: RTL and testbench

DEBUG_TRACE_STREAMER -- requirements
Module: debug_trace_streamer

---
 rtl/trace_pkg.sv | 39 +++
 rtl/trace_fifo.sv | 67 ++++++
 rtl/debug_trace_streamer.sv | 160 ++++++++++++++++
 tb/tb_debug_trace_streamer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the debug trace streamer: record layout, sizes,
// default header byte and serializer state encoding.
package trace_pkg;

  localparam int unsigned RecWidth    = 104;
  localparam int unsigned RecBytes    = 14;
  localparam int unsigned BodyLen     = 13;
  localparam logic [7:0]  DefaultSync = 8'hA5;

  typedef logic [RecWidth-1:0] record_t;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StBody
  } state_e;

  // Record layout, MSB first: PC, instruction, ALU result, flags byte.
  function automatic record_t pack_record(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [31:0] alu,
    input logic        reg_write,
    input logic        mem_write,
    input logic [4:0]  rd
  );
    return {pc, instr, alu, reg_write, mem_write, 1'b0, rd};
  endfunction

  // Body byte idx (0..12) on the wire: each 32-bit field little-endian, then flags.
  function automatic logic [7:0] body_byte(input record_t rec, input logic [3:0] idx);
    record_t body;
    record_t shifted;
    body    = {rec[7:0], rec[39:8], rec[71:40], rec[103:72]};
    shifted = body >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the trace streamer. A push while full is still accepted
// when a pop happens in the same cycle; storage itself is not reset.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 104
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage write port.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/debug_trace_streamer.sv
// Captures retired-instruction records into a FIFO and serializes each one as
// a SYNC header byte followed by 13 body bytes over a valid/ready byte stream.
// Records arriving while the FIFO is full are dropped and counted.
module debug_trace_streamer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter logic [7:0]  SYNC  = DefaultSync
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iValid,
  input  logic [31:0] iPC,
  input  logic [31:0] iInstruction,
  input  logic [31:0] iAluResult,
  input  logic [4:0]  iRd,
  input  logic        iRegWrite,
  input  logic        iMemWrite,
  input  logic        iEnable,
  input  logic        iClearOverflow,
  output logic [7:0]  oByte,
  output logic        oValid,
  input  logic        iReady,
  output logic        oOverflow,
  output logic [7:0]  oDropCount
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      drops_q, drops_d;

  logic            capture;
  logic            xfer;
  logic            last_idx;
  logic            pop;
  logic            drop;
  record_t         wr_rec;
  record_t         head_rec;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  assign capture  = iValid && iEnable;
  assign xfer     = oValid && iReady;
  assign last_idx = (idx_q == 4'(BodyLen - 1));
  assign wr_rec   = pack_record(iPC, iInstruction, iAluResult, iRegWrite, iMemWrite, iRd);
  assign drop     = capture && fifo_full && !pop;

  trace_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(RecWidth)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .push_i (capture),
    .wdata_i(wr_rec),
    .pop_i  (pop),
    .rdata_o(head_rec),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Serializer state, byte index and registered output byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
    end
  end

  // Next state; the byte for the state being entered is loaded alongside it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StHeader;
          byte_d  = SYNC;
        end
      end
      StHeader: begin
        if (xfer) begin
          state_d = StBody;
          idx_d   = '0;
          byte_d  = body_byte(head_rec, 4'd0);
        end
      end
      StBody: begin
        if (xfer) begin
          if (last_idx) begin
            idx_d = '0;
            // A push in the popping cycle is always accepted, so it keeps the FIFO non-empty.
            if (fifo_count > CntW'(1) || capture) begin
              state_d = StHeader;
              byte_d  = SYNC;
            end else begin
              state_d = StIdle;
              byte_d  = 8'h00;
            end
          end else begin
            idx_d  = idx_q + 4'd1;
            byte_d = body_byte(head_rec, idx_q + 4'd1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        byte_d  = 8'h00;
      end
    endcase
  end

  // Stream outputs and the FIFO pop on acceptance of a record's last byte.
  always_comb begin
    oValid = (state_q != StIdle);
    oByte  = byte_q;
    pop    = (state_q == StBody) && xfer && last_idx;
  end

  // Overflow next state; a drop wins over a coincident clear.
  always_comb begin
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (drop) begin
      ovf_d   = 1'b1;
      drops_d = iClearOverflow ? 8'd1 : ((drops_q == 8'hFF) ? 8'hFF : drops_q + 8'd1);
    end else if (iClearOverflow) begin
      ovf_d   = 1'b0;
      drops_d = 8'd0;
    end
  end

  // Overflow status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q   <= 1'b0;
      drops_q <= 8'd0;
    end else begin
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  assign oOverflow  = ovf_q;
  assign oDropCount = drops_q;

endmodule

// File: tb/tb_debug_trace_streamer.sv
// Scoreboard bench: a record-level model predicts the byte stream and drop
// status; a monitor compares every accepted byte against the predicted queue.
module tb_debug_trace_streamer;

  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        iValid = 1'b0;
  logic [31:0] iPC = '0;
  logic [31:0] iInstruction = '0;
  logic [31:0] iAluResult = '0;
  logic [4:0]  iRd = '0;
  logic        iRegWrite = 1'b0;
  logic        iMemWrite = 1'b0;
  logic        iEnable = 1'b1;
  logic        iClearOverflow = 1'b0;
  logic        iReady = 1'b1;
  logic [7:0]  oByte;
  logic        oValid;
  logic        oOverflow;
  logic [7:0]  oDropCount;

  always #5 clock = ~clock;

  debug_trace_streamer #(
    .DEPTH(DEPTH),
    .SYNC (SYNC)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .iValid        (iValid),
    .iPC           (iPC),
    .iInstruction  (iInstruction),
    .iAluResult    (iAluResult),
    .iRd           (iRd),
    .iRegWrite     (iRegWrite),
    .iMemWrite     (iMemWrite),
    .iEnable       (iEnable),
    .iClearOverflow(iClearOverflow),
    .oByte         (oByte),
    .oValid        (oValid),
    .iReady        (iReady),
    .oOverflow     (oOverflow),
    .oDropCount    (oDropCount)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  // Model state: records held, bytes accepted so far, overflow status.
  int          occ = 0;
  int unsigned xfer_cnt = 0;
  logic        m_ovf = 1'b0;
  int          m_drops = 0;
  logic        p_xfer, p_pop, p_cap, p_acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic push_expected();
    exp_q.push_back(SYNC);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(iPC >> (8 * i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(iInstruction >> (8 * i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(iAluResult >> (8 * i)));
    exp_q.push_back({iRegWrite, iMemWrite, 1'b0, iRd});
  endtask

  // Predictor: inputs are stable at the falling edge and describe the next rising edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      occ      = 0;
      xfer_cnt = 0;
      m_ovf    = 1'b0;
      m_drops  = 0;
    end else begin
      check("overflow_flag", oOverflow, m_ovf);
      check("drop_count", oDropCount, m_drops);
      p_xfer = oValid && iReady;
      p_pop  = p_xfer && (xfer_cnt % 14 == 13);
      if (p_xfer) xfer_cnt++;
      p_cap = iValid && iEnable;
      p_acc = p_cap && (occ < int'(DEPTH) || p_pop);
      if (p_acc) push_expected();
      if (p_cap && !p_acc) begin
        m_ovf   = 1'b1;
        m_drops = iClearOverflow ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (iClearOverflow) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      occ = occ + (p_acc ? 1 : 0) - (p_pop ? 1 : 0);
    end
  end

  // Monitor: compares accepted bytes and checks stalls hold the output steady.
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_b = 8'h00;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("stall_valid_hold", oValid, 1'b1);
        check("stall_byte_hold", oByte, prev_b);
      end
      if (oValid && iReady) begin
        got_q.push_back(oByte);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL stream_byte: got %0h, expected no byte (queue empty)", oByte);
        end else begin
          check("stream_byte", oByte, exp_q.pop_front());
        end
      end
      prev_v = oValid;
      prev_r = iReady;
      prev_b = oByte;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_fields();
    iPC          = $urandom;
    iInstruction = $urandom;
    iAluResult   = $urandom;
    iRd          = 5'($urandom);
    iRegWrite    = 1'($urandom);
    iMemWrite    = 1'($urandom);
  endtask

  task automatic capture_rand();
    rand_fields();
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || oValid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", oValid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, oValid, 1'b0);
    check({tag, "_byte"}, oByte, 8'h00);
    check({tag, "_overflow"}, oOverflow, 1'b0);
    check({tag, "_drops"}, oDropCount, 8'h00);
  endtask

  logic [7:0] golden [14];
  int         first_s, last_s;

  initial begin
    golden = '{8'hA5, 8'h00, 8'h00, 8'h40, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h05, 8'h00, 8'h00, 8'h00, 8'h81};

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Known record, first-record latency.
    got_q.delete();
    iReady       = 1'b1;
    iPC          = 32'h0040_0000;
    iInstruction = 32'h0050_0093;
    iAluResult   = 32'h0000_0005;
    iRd          = 5'd1;
    iRegWrite    = 1'b1;
    iMemWrite    = 1'b0;
    iValid       = 1'b1;
    tick();
    iValid = 1'b0;
    check("latency_not_yet_valid", oValid, 1'b0);
    tick();
    check("latency_valid", oValid, 1'b1);
    check("latency_sync", oByte, SYNC);
    wait_drain(100);
    check("known_record_len", got_q.size(), 14);
    for (int i = 0; i < 14; i++) begin
      if (i < got_q.size()) check("known_record_byte", got_q[i], golden[i]);
    end

    // Consumer stall mid-body.
    capture_rand();
    repeat (6) tick();
    iReady = 1'b0;
    repeat (5) tick();
    iReady = 1'b1;
    wait_drain(100);

    // Back-to-back records stream without bubbles.
    first_s = -1;
    last_s  = -1;
    for (int s = 0; s < 63; s++) begin
      if (s < 3) begin
        rand_fields();
        iValid = 1'b1;
      end else begin
        iValid = 1'b0;
      end
      tick();
      if (oValid) begin
        if (first_s < 0) first_s = s;
        last_s = s;
      end
    end
    check("stream_first_valid", first_s, 1);
    check("stream_last_valid", last_s, 42);
    wait_drain(100);

    // Overfill: 10 captures into 8 slots, then push-with-pop while full, then clear+drop.
    iReady         = 1'b0;
    iClearOverflow = 1'b1;
    tick();
    iClearOverflow = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rand_fields();
      iValid = 1'b1;
      tick();
    end
    iValid = 1'b0;
    check("overfill_drops", oDropCount, 8'd2);
    check("overfill_flag", oOverflow, 1'b1);
    iReady = 1'b1;
    repeat (13) tick();
    capture_rand();
    iReady = 1'b0;
    check("full_pushpop_no_drop", oDropCount, 8'd2);
    rand_fields();
    iValid         = 1'b1;
    iClearOverflow = 1'b1;
    tick();
    iValid         = 1'b0;
    iClearOverflow = 1'b0;
    check("clear_with_drop_flag", oOverflow, 1'b1);
    check("clear_with_drop_count", oDropCount, 8'd1);
    iReady = 1'b1;
    wait_drain(400);

    // Reset in the middle of a record.
    capture_rand();
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    reset_n = 1'b1;
    tick();
    got_q.delete();
    capture_rand();
    wait_drain(100);
    check("post_reset_len", got_q.size(), 14);
    if (got_q.size() > 0) check("post_reset_sync", got_q[0], SYNC);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rand_fields();
      iValid         = ($urandom_range(0, 2) == 0);
      iEnable        = ($urandom_range(0, 7) != 0);
      iReady         = ($urandom_range(0, 3) != 0);
      iClearOverflow = ($urandom_range(0, 39) == 0);
      tick();
    end
    iValid         = 1'b0;
    iEnable        = 1'b1;
    iClearOverflow = 1'b0;
    iReady         = 1'b1;
    wait_drain(3000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
